// File: rtl/as512512512_spi_flash_rd_if.sv
// rtl/as512512512_spi_flash_rd_if.sv - request, read-data and byte-engine signals of the flash read sequencer
interface as512512512_spi_flash_rd_if;
  logic        req_valid;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        req_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic        CS_N;
  logic [7:0]  spi_din;
  logic        spi_start;
  logic        spi_busy;
  logic [7:0]  spi_dout;

  modport slave (
    input  req_valid, req_addr, req_len, rd_ready, spi_busy, spi_dout,
    output req_ready, rd_data, rd_valid, busy, CS_N, spi_din, spi_start
  );

  modport master (
    output req_valid, req_addr, req_len, rd_ready, spi_busy, spi_dout,
    input  req_ready, rd_data, rd_valid, busy, CS_N, spi_din, spi_start
  );
endinterface

// File: rtl/as512512512_spi_flash_rd.sv
// rtl/as512512512_spi_flash_rd.sv - SPI flash READ (0x03) sequencer feeding the SPI byte engine
module as512512512_spi_flash_rd #(
  parameter int unsigned CS_GAP = 4,
  parameter logic [7:0]  RD_CMD = 8'h03
) (
  input logic                         clk,
  input logic                         rst,
  as512512512_spi_flash_rd_if.slave   bus
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_CMD   = 4'd1;
  localparam logic [3:0] ST_A2    = 4'd2;
  localparam logic [3:0] ST_A1    = 4'd3;
  localparam logic [3:0] ST_A0    = 4'd4;
  localparam logic [3:0] ST_DATA  = 4'd5;
  localparam logic [3:0] ST_OUT   = 4'd6;
  localparam logic [3:0] ST_DESEL = 4'd7;

  // SETUP only occurs once, before the command byte, to give CS_N a cycle of setup
  localparam logic [1:0] PH_SETUP   = 2'd0;
  localparam logic [1:0] PH_ISSUE   = 2'd1;
  localparam logic [1:0] PH_WAIT_HI = 2'd2;
  localparam logic [1:0] PH_WAIT_LO = 2'd3;

  logic [3:0]  state;
  logic [1:0]  phase;
  logic [23:0] addr_q;
  logic [8:0]  remain;
  logic [7:0]  gap;
  logic [7:0]  rd_data_q;
  logic        rd_valid_q;
  logic [7:0]  tx_byte;
  logic        in_byte;
  logic        accept;

  assign in_byte = (state == ST_CMD) || (state == ST_A2) || (state == ST_A1) ||
                   (state == ST_A0)  || (state == ST_DATA);
  assign accept  = bus.req_valid && bus.req_ready;

  assign bus.req_ready = (state == ST_IDLE) && (gap == 8'd0);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.CS_N      = (state == ST_IDLE) || (state == ST_DESEL);
  assign bus.spi_start = in_byte && (phase == PH_ISSUE);
  assign bus.spi_din   = tx_byte;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

  // Byte presented to the engine for the current phase; dummy zeros clock in read data
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      ST_CMD:  tx_byte = RD_CMD;
      ST_A2:   tx_byte = addr_q[23:16];
      ST_A1:   tx_byte = addr_q[15:8];
      ST_A0:   tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Transaction sequencer: command/address/data bytes, output hold, and CS deselect gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PH_SETUP;
      addr_q     <= 24'd0;
      remain     <= 9'd0;
      gap        <= 8'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q <= bus.req_addr;
            remain <= (bus.req_len == 8'd0) ? 9'd256 : {1'b0, bus.req_len};
            state  <= ST_CMD;
            phase  <= PH_SETUP;
          end
        end

        ST_CMD, ST_A2, ST_A1, ST_A0, ST_DATA: begin
          case (phase)
            PH_SETUP:   phase <= PH_ISSUE;
            PH_ISSUE:   phase <= PH_WAIT_HI;
            PH_WAIT_HI: if (bus.spi_busy) phase <= PH_WAIT_LO;
            default: begin
              // First cycle busy is seen low: the engine's received byte is valid now
              if (!bus.spi_busy) begin
                phase <= PH_ISSUE;
                case (state)
                  ST_CMD:  state <= ST_A2;
                  ST_A2:   state <= ST_A1;
                  ST_A1:   state <= ST_A0;
                  ST_A0:   state <= ST_DATA;
                  default: begin
                    state      <= ST_OUT;
                    rd_data_q  <= bus.spi_dout;
                    rd_valid_q <= 1'b1;
                  end
                endcase
              end
            end
          endcase
        end

        ST_OUT: begin
          // No new byte is issued until the consumer takes this one, pausing the SPI clock
          if (bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            remain     <= remain - 9'd1;
            if (remain == 9'd1) begin
              state <= ST_DESEL;
              gap   <= 8'(CS_GAP);
            end else begin
              state <= ST_DATA;
              phase <= PH_ISSUE;
            end
          end
        end

        ST_DESEL: begin
          if (gap <= 8'd1) begin
            state <= ST_IDLE;
            gap   <= 8'd0;
          end else begin
            gap <= gap - 8'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/as512512512_spi_flash_rd.md
Name: as512512512_spi_flash_rd

Overview:
- Sequencer that sits directly upstream of the team's SPI byte engine (as512512512_spi).
- Turns a read request (24-bit address, byte count) into a standard SPI flash READ (0x03) transaction: drives flash chip-select, feeds command and address bytes to the byte engine, then streams returned data bytes out over a valid/ready port.
- Used by the boot/ROM-fetch path to pull program data from external SPI flash.

Parameters:
- CS_GAP, 4, minimum cycles CS_N is held high after a transaction before the next one may start (range 1..255).
- RD_CMD, 8'h03, command byte sent first.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  read request present
- req_addr  in  24  flash byte address, sent MSB first
- req_len  in  8  bytes to read; 0 means 256
- req_ready  out  1  high only in IDLE with gap elapsed; request accepted when req_valid & req_ready
- rd_data  out  8  returned byte
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- busy  out  1  high from accept until return to IDLE
- CS_N  out  1  flash chip select, active low
- spi_din  out  8  byte to byte engine
- spi_start  out  1  one-cycle start pulse to byte engine
- spi_busy  in  1  byte engine busy
- spi_dout  in  8  byte engine received byte, valid when spi_busy low after a transfer

Behaviour:
- Reset: CS_N=1, spi_start=0, spi_din=0, rd_valid=0, rd_data=0, busy=0, gap counter loaded so req_ready=1 one cycle after reset release. Reset mid-transaction aborts immediately: CS_N high the next cycle, any held rd_data dropped.
- Byte-engine contract (decided): spi_start is a single-cycle pulse with spi_din stable that cycle. spi_busy rises up to 2 cycles after start. Sequencer waits for spi_busy=1, then spi_busy=0; spi_dout is captured on the first cycle spi_busy is seen low.
- Each byte uses sub-phases ISSUE (start=1) -> WAIT_HI -> WAIT_LO.
- Top FSM: IDLE -> CMD -> A2 -> A1 -> A0 -> DATA -> OUT -> (DATA | DESEL) -> IDLE.
- IDLE: on accept, latch addr and length (9-bit remaining count; 0 -> 256). CS_N goes low the cycle after accept, and ISSUE of CMD occurs one cycle after that (CS setup >= 1 cycle).
- CMD sends RD_CMD. A2/A1/A0 send addr[23:16], [15:8], [7:0]. Received bytes in these phases are discarded.
- DATA sends 8'h00; captured spi_dout goes to rd_data with rd_valid=1 (state OUT).
- OUT: hold rd_data/rd_valid stable until rd_ready. On the handshake cycle rd_valid drops next cycle and the remaining count decrements. Nonzero -> DATA (ISSUE next cycle). Zero -> DESEL. No byte is issued while rd_valid is high, so the SPI clock pauses and CS_N stays low.
- DESEL: CS_N=1, gap counter = CS_GAP, decrement each cycle. req_ready asserts once the counter reaches 0 and state is IDLE.
- busy is high from the cycle after accept through DESEL inclusive.
- Address does not wrap internally; flash handles wrap past 0xFFFFFF.
- req_valid while busy is ignored (req_ready=0). The request is not latched twice.

Test Plan:
- Reset then req addr=0x123456, len=1, byte model returns 0xA5 on data byte -> spi_din sequence 03,12,34,56,00; CS_N low across all 5 bytes; one rd_valid with rd_data=0xA5; CS_N high after; req_ready back after CS_GAP=4 cycles.
- len=3, rd_ready always 1, model returns 11,22,33 -> exactly 3 rd_valid pulses with data 11,22,33 in order, then DESEL.
- len=2, rd_ready held 0 for 10 cycles on first byte -> rd_data stays 0x11 and rd_valid stays 1 for 10 cycles; no spi_start during the stall; CS_N stays low.
- len=0 -> exactly 256 data bytes delivered, busy falls only after the 256th handshake.
- Assert rst during A1 -> next cycle CS_N=1, rd_valid=0, spi_start=0; new request after reset completes normally.
- Byte model with 2-cycle spi_busy latency, and req_valid pulsed during a transfer -> no lost or duplicated start; second request ignored until req_ready=1.
